shift_seq_ctrl: RTL

- Multi-cycle sequencer for the ARM data-processing operand-2 shifter. It resolves both immediate form (imm8 rotated right by 2*rot) and register form (LSL/LSR/ASR/ROR/RRX of Rm).
- Sits between decode and the ALU. It shifts iteratively, STEP bits per cycle, so the shift hardware stays small.
- Produces the shifter result and shifter carry-out, with valid/ready handshakes on both sides.

---
 rtl/shift_seq_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// Iterative ARM operand-2 shifter sequencer: STEP bit positions per SHIFT cycle.
// Define SHIFT_SEQ_FAST_IMM_EN to resolve immediate-form rotates at accept.
module shift_seq_ctrl #(
  parameter int unsigned STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_imm,
  input  logic [11:0] operand2,
  input  logic [31:0] rm_value,
  input  logic [7:0]  rs_amount,
  input  logic        carry_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        carry_out,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [2:0] {OpLsl, OpLsr, OpAsr, OpRor, OpRrx} op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] val_q, val_d;
  logic        c_q, c_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic        co_q, co_d;

  // Decoded request at the accept edge; acc_n == 0 means the result is acc_val/acc_c.
  op_e         acc_op;
  logic [31:0] acc_val;
  logic        acc_c;
  logic [5:0]  acc_n;

`ifdef SHIFT_SEQ_FAST_IMM_EN
  logic [5:0]  imm_rot;
  logic [63:0] imm_wide;
  assign imm_rot  = {1'b0, operand2[11:8], 1'b0};
  assign imm_wide = {24'b0, operand2[7:0], 24'b0, operand2[7:0]} >> imm_rot;
`endif

  always_comb begin
    acc_op  = OpRor;
    acc_val = rm_value;
    acc_c   = carry_in;
    acc_n   = 6'd0;
    if (op_imm) begin
`ifdef SHIFT_SEQ_FAST_IMM_EN
      acc_val = imm_wide[31:0];
      acc_c   = (imm_rot == 6'd0) ? carry_in : imm_wide[31];
`else
      acc_val = {24'b0, operand2[7:0]};
      acc_n   = {1'b0, operand2[11:8], 1'b0};
`endif
    end else begin
      unique case (operand2[6:5])
        2'b00:   acc_op = OpLsl;
        2'b01:   acc_op = OpLsr;
        2'b10:   acc_op = OpAsr;
        default: acc_op = OpRor;
      endcase
      if (!operand2[4]) begin
        if (operand2[11:7] != 5'd0) begin
          acc_n = {1'b0, operand2[11:7]};
        end else begin
          // Zero immediate amounts encode LSR/ASR #32 and RRX.
          unique case (operand2[6:5])
            2'b00:   acc_n = 6'd0;
            2'b11: begin
              acc_op = OpRrx;
              acc_n  = 6'd1;
            end
            default: acc_n = 6'd32;
          endcase
        end
      end else if (rs_amount != 8'd0) begin
        if (operand2[6:5] != 2'b11) begin
          acc_n = (rs_amount > 8'd33) ? 6'd33 : rs_amount[5:0];
        end else begin
          acc_n = {1'b0, rs_amount[4:0]};
          if (rs_amount[4:0] == 5'd0) acc_c = rm_value[31];
        end
      end
    end
  end

  // One SHIFT cycle: up to STEP single-bit steps, carry = last bit shifted out.
  logic [5:0]  k;
  logic [31:0] sh_v;
  logic        sh_c;

  always_comb begin
    k    = (cnt_q < 6'(STEP)) ? cnt_q : 6'(STEP);
    sh_v = val_q;
    sh_c = c_q;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (6'(i) < k) begin
        case (op_q)
          OpLsl: begin
            sh_c = sh_v[31];
            sh_v = {sh_v[30:0], 1'b0};
          end
          OpLsr: begin
            sh_c = sh_v[0];
            sh_v = {1'b0, sh_v[31:1]};
          end
          OpAsr: begin
            sh_c = sh_v[0];
            sh_v = {sh_v[31], sh_v[31:1]};
          end
          OpRrx: begin
            sh_v = {sh_c, sh_v[31:1]};
            sh_c = val_q[0];
          end
          default: begin
            sh_c = sh_v[0];
            sh_v = {sh_v[0], sh_v[31:1]};
          end
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    val_d   = val_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    co_d    = co_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d  = acc_op;
          val_d = acc_val;
          c_d   = acc_c;
          cnt_d = acc_n;
          if (acc_n == 6'd0) begin
            state_d = StDone;
            res_d   = acc_val;
            co_d    = acc_c;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        val_d = sh_v;
        c_d   = sh_c;
        cnt_d = cnt_q - k;
        if (cnt_q == k) begin
          state_d = StDone;
          res_d   = sh_v;
          co_d    = sh_c;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpLsl;
      val_q   <= 32'd0;
      c_q     <= 1'b0;
      cnt_q   <= 6'd0;
      res_q   <= 32'd0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      val_q   <= val_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      co_q    <= co_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = res_q;
  assign carry_out = co_q;

endmodule
